serial_unpool: RTL and testbench

- Parallel-to-serial converter; the transmit-side counterpart of the serial_pool deserializer.
- Takes an N-bit two's-complement word on a load strobe and emits it LSB-first, one bit per clk, followed by EXT extension bits.
- Output is a start-aligned fbit flag plus a bit stream, the form expected by serial_mult / serial_subs / rbf_actfunc_serial inputs.
- Holds one pending word, so frames can run back-to-back with zero gap.

---
 rtl/serial_unpool.sv | 137 +++++++++++++
 tb/tb_serial_unpool.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_unpool.sv
// serial_unpool: parallel-to-serial converter.
// Takes an N-bit two's-complement word on a load strobe and sends it out
// LSB-first, one bit per clock, followed by EXT extension bits. A start-aligned
// fbit flag marks bit 0 and last marks bit L-1. One pending slot lets frames
// run back-to-back with no idle cycle between them.
module serial_unpool #(
  parameter int N   = 16,
  parameter int EXT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] x,
  input  logic         sext,
  output logic         ready,
  output logic         y,
  output logic         fbit,
  output logic         last,
  output logic         busy,
  output logic         ovf
);

  localparam int L  = N + EXT;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(L - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic           e_q, e_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   pw_q, pw_d;
  logic           ps_q, ps_d;
  logic           pv_q, pv_d;
  logic           y_q, y_d;
  logic           fbit_q, fbit_d;
  logic           last_q, last_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;

  // Next-state logic: frame sequencing, pending-slot handling and the output
  // bits that the next cycle will present.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    ps_d    = ps_q;
    pv_d    = pv_q;
    ovf_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d    = x;
          e_d     = sext & x[N-1];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (pv_q) begin
            // Queued word goes straight out; a load arriving now sees ready=0.
            sr_d  = pw_q;
            e_d   = ps_q & pw_q[N-1];
            pv_d  = 1'b0;
            ovf_d = load;
          end else if (load) begin
            sr_d = x;
            e_d  = sext & x[N-1];
          end else begin
            state_d = IDLE;
          end
        end else if (load) begin
          if (pv_q) begin
            ovf_d = 1'b1;
          end else begin
            pw_d = x;
            ps_d = sext;
            pv_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    y_d    = busy_d & ((32'(cnt_d) < N) ? sr_d[0] : e_d);
    fbit_d = busy_d && (cnt_d == '0);
    last_d = busy_d && (cnt_d == LAST_CNT);
  end

  // State and output registers; reset aborts any frame and empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      e_q     <= 1'b0;
      cnt_q   <= '0;
      pw_q    <= '0;
      ps_q    <= 1'b0;
      pv_q    <= 1'b0;
      y_q     <= 1'b0;
      fbit_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      ps_q    <= ps_d;
      pv_q    <= pv_d;
      y_q     <= y_d;
      fbit_q  <= fbit_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = ~pv_q;
  assign y     = y_q;
  assign fbit  = fbit_q;
  assign last  = last_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_unpool.sv
// Testbench for serial_unpool: a frame-queue model checks the N=16/EXT=16
// instance every cycle; directed frames pin expected bit patterns, and a
// second EXT=0 instance is checked with literal expectations.
module tb_serial_unpool;

  localparam int N = 16;
  localparam int L = 32;

  logic        clk, rst;
  logic        load, sext;
  logic [15:0] x;
  logic        ready, y, fbit, last, busy, ovf;

  logic        load0, sext0;
  logic [15:0] x0;
  logic        ready0, y0, fbit0, last0, busy0, ovf0;

  int tests  = 0;
  int failed = 0;

  serial_unpool #(.N(16), .EXT(16)) dut (
    .clk(clk), .rst(rst), .load(load), .x(x), .sext(sext),
    .ready(ready), .y(y), .fbit(fbit), .last(last), .busy(busy), .ovf(ovf)
  );

  serial_unpool #(.N(16), .EXT(0)) dut0 (
    .clk(clk), .rst(rst), .load(load0), .x(x0), .sext(sext0),
    .ready(ready0), .y(y0), .fbit(fbit0), .last(last0), .busy(busy0), .ovf(ovf0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a frame is the list of bits still to appear on y.
  typedef logic frame_t[$];

  frame_t cur;
  frame_t pend;
  bit     has_pend = 1'b0;
  logic   m_ovf    = 1'b0;

  function automatic frame_t expand(input logic [15:0] w, input logic s);
    frame_t f;
    for (int i = 0; i < L; i++)
      f.push_back(i < N ? w[i] : (s & w[N-1]));
    return f;
  endfunction

  task automatic modelStep();
    if (rst) begin
      cur.delete();
      pend.delete();
      has_pend = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      m_ovf = 1'b0;
      if (cur.size() == 0) begin
        if (load) cur = expand(x, sext);
      end else begin
        void'(cur.pop_front());
        if (cur.size() == 0) begin
          if (has_pend) begin
            cur      = pend;
            has_pend = 1'b0;
            if (load) m_ovf = 1'b1;
          end else if (load) begin
            cur = expand(x, sext);
          end
        end else if (load) begin
          if (has_pend) m_ovf = 1'b1;
          else begin
            pend     = expand(x, sext);
            has_pend = 1'b1;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of the main instance against the model.
  initial forever begin
    @(negedge clk);
    checkOutput("busy",  32'(busy),  32'(cur.size() != 0));
    checkOutput("y",     32'(y),     32'(cur.size() != 0 ? cur[0] : 1'b0));
    checkOutput("fbit",  32'(fbit),  32'(cur.size() == L));
    checkOutput("last",  32'(last),  32'(cur.size() == 1));
    checkOutput("ready", 32'(ready), 32'(!has_pend));
    checkOutput("ovf",   32'(ovf),   32'(m_ovf));
  end

  // Presents inputs for one edge, then returns 1 time unit after that edge.
  task automatic applyStimulus(input logic ld, input logic [15:0] xv, input logic sx);
    load = ld;
    x    = xv;
    sext = sx;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  typedef struct {
    logic [15:0] xv;
    logic        sx;
    logic [31:0] bits;
  } frame_vec_t;

  frame_vec_t vecs[3] = '{
    '{16'h8001, 1'b1, 32'hFFFF_8001},
    '{16'h8001, 1'b0, 32'h0000_8001},
    '{16'h7FFE, 1'b1, 32'h0000_7FFE}
  };

  logic [31:0] bits;
  int          fpos, lpos, fcount, bcount;
  int          fposq[$];
  int          lposq[$];
  logic [15:0] bits0;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; load = 1'b0; x = '0; sext = 1'b0;
    load0 = 1'b0; x0 = '0; sext0 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_y",     32'(y),     32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_busy",  32'(busy),  32'd0);
    checkOutput("reset_ovf",   32'(ovf),   32'd0);
    rst = 1'b0;
    applyStimulus(0, 0, 0);

    // Single frames from IDLE.
    foreach (vecs[k]) begin
      bits = '0; fpos = -1; lpos = -1;
      applyStimulus(1, vecs[k].xv, vecs[k].sx);
      for (int i = 0; i < 40; i++) begin
        if (busy && i < 32) bits[i] = y;
        if (fbit && fpos < 0) fpos = i;
        if (last && lpos < 0) lpos = i;
        if (i == 32) begin
          checkOutput("idle_busy_after_frame", 32'(busy), 32'd0);
          checkOutput("idle_y_after_frame",    32'(y),    32'd0);
        end
        applyStimulus(0, 0, 0);
      end
      checkOutput("frame_bits", bits, vecs[k].bits);
      checkOutput("frame_fbit_pos", 32'(fpos), 32'd0);
      checkOutput("frame_last_pos", 32'(lpos), 32'd31);
    end

    // Back-to-back: A then B three cycles later.
    bits = '0;
    for (int c = 0; c < 80; c++) begin
      if (c == 0) applyStimulus(1, 16'h0003, 0);
      else if (c == 3) applyStimulus(1, 16'hFFFE, 1);
      else applyStimulus(0, 0, 0);
      if (c == 3) checkOutput("ready_after_b_load", 32'(ready), 32'd0);
      if (fbit) fposq.push_back(c);
      if (last) lposq.push_back(c);
      if (fposq.size() == 2 && busy && (c - fposq[1]) < 32) bits[c - fposq[1]] = y;
    end
    checkOutput("b2b_fbit_count", 32'(fposq.size()), 32'd2);
    checkOutput("b2b_last_count", 32'(lposq.size()), 32'd2);
    checkOutput("b2b_a_last", 32'(lposq.size() > 0 ? lposq[0] : -1), 32'd31);
    checkOutput("b2b_b_fbit", 32'(fposq.size() > 1 ? fposq[1] : -1), 32'd32);
    checkOutput("b2b_b_bits", bits, 32'hFFFF_FFFE);

    // Overflow: three loads on consecutive edges.
    fcount = 0;
    for (int c = 0; c < 80; c++) begin
      if (c == 0) applyStimulus(1, 16'h1111, 0);
      else if (c == 1) applyStimulus(1, 16'h2222, 1);
      else if (c == 2) applyStimulus(1, 16'h3333, 0);
      else applyStimulus(0, 0, 0);
      if (c == 1) checkOutput("ovf_no_pulse_on_pend", 32'(ovf), 32'd0);
      if (c == 2) checkOutput("ovf_pulse_on_drop",    32'(ovf), 32'd1);
      if (c == 3) checkOutput("ovf_single_cycle",     32'(ovf), 32'd0);
      if (fbit) fcount++;
    end
    checkOutput("ovf_frames_emitted", 32'(fcount), 32'd2);

    // Reset mid-frame with a word pending.
    applyStimulus(1, 16'h00FF, 0);
    applyStimulus(1, 16'h1234, 0);
    for (int c = 2; c <= 7; c++) applyStimulus(0, 0, 0);
    checkOutput("rst_pre_y_bit7", 32'(y),     32'd1);
    checkOutput("rst_pre_ready",  32'(ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid_y",     32'(y),     32'd0);
    checkOutput("rst_mid_busy",  32'(busy),  32'd0);
    checkOutput("rst_mid_fbit",  32'(fbit),  32'd0);
    checkOutput("rst_mid_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    bcount = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 0, 0);
      if (busy) bcount++;
    end
    checkOutput("rst_no_bits_after", 32'(bcount), 32'd0);

    // EXT=0 instance.
    bits0 = '0; fpos = -1; lpos = -1;
    load0 = 1'b1; x0 = 16'hA5A5; sext0 = 1'b1;
    applyStimulus(0, 0, 0);
    load0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy0 && i < 16) bits0[i] = y0;
      if (fbit0 && fpos < 0) fpos = i;
      if (last0 && lpos < 0) lpos = i;
      if (i == 16) checkOutput("ext0_idle_after", 32'(busy0), 32'd0);
      applyStimulus(0, 0, 0);
    end
    checkOutput("ext0_bits", 32'(bits0), 32'h0000_A5A5);
    checkOutput("ext0_fbit_pos", 32'(fpos), 32'd0);
    checkOutput("ext0_last_pos", 32'(lpos), 32'd15);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
